// File: rtl/sequential_select_pkg.sv
// sequential_select_pkg: shared word width, state encoding and bit order for the serializer/collector link
package sequential_select_pkg;
  localparam int DEF_WIDTH = 8;
  localparam bit LSB_FIRST = 1'b1;
  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;
endpackage

// File: rtl/bit_index_counter.sv
// bit_index_counter: mod-WIDTH index (clk, rst_n async low, clr sync, en) -> cnt, wrap when en at WIDTH-1
module bit_index_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);
  assign wrap = en && cnt == CNT_W'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + CNT_W'(1) : cnt;
endmodule

// File: rtl/sequential_collect.sv
// sequential_collect: serial-to-parallel receiver (clk, master_rst_n, start, ser_in) -> par_out, valid, busy, bit_idx, word_cnt
module sequential_collect
  import sequential_select_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CNT_W  = $clog2(WIDTH),
  parameter int WCNT_W = 8
) (
  input  logic              clk,
  input  logic              master_rst_n,
  input  logic              start,
  input  logic              ser_in,
  output logic [WIDTH-1:0]  par_out,
  output logic              valid,
  output logic              busy,
  output logic [CNT_W-1:0]  bit_idx,
  output logic [WCNT_W-1:0] word_cnt
);
  state_t           state;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_n;
  logic [CNT_W-1:0] slot;
  logic             done;
  bit_index_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_idx (
    .clk   (clk),
    .rst_n (master_rst_n),
    .clr   (!start),
    .en    (start),
    .cnt   (bit_idx),
    .wrap  (done)
  );
  assign busy = state == COLLECT;
  assign slot = LSB_FIRST ? bit_idx : ~bit_idx;
  always_comb begin
    sr_n       = sr_q;
    sr_n[slot] = ser_in;
  end
  always_ff @(posedge clk or negedge master_rst_n)
    if (!master_rst_n) begin
      state    <= IDLE;
      sr_q     <= '0;
      par_out  <= '0;
      valid    <= 1'b0;
      word_cnt <= '0;
    end else begin
      state <= start ? COLLECT : IDLE;
      sr_q  <= start && !done ? sr_n : '0;
      valid <= done;
      if (done) begin
        par_out  <= sr_n;
        word_cnt <= word_cnt + WCNT_W'(1);
      end
    end
endmodule

// File: tb/tb_sequential_collect.sv
// tb_sequential_collect: scoreboard bench for sequential_collect with directed words and boundaries
module tb_sequential_collect;
  typedef struct {
    logic [7:0] d;
    logic [7:0] c;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       master_rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ser_in = 1'b0;
  logic [7:0] par_out;
  logic       valid;
  logic       busy;
  logic [2:0] bit_idx;
  logic [7:0] word_cnt;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_v = -1000;
  logic [7:0] wc = 8'd0;

  sequential_collect dut (
    .clk          (clk),
    .master_rst_n (master_rst_n),
    .start        (start),
    .ser_in       (ser_in),
    .par_out      (par_out),
    .valid        (valid),
    .busy         (busy),
    .bit_idx      (bit_idx),
    .word_cnt     (word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_par_out"}, 32'(par_out), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_bit_idx"}, 32'(bit_idx), 32'd0);
    chk({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start  = 1'b1;
      ser_in = w[i];
    end
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    wc = wc + 8'd1;
    q.push_back('{w, wc, gap});
    send_bits(w, 8);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start  = 1'b0;
      ser_in = ~ser_in;
    end
  endtask

  always @(negedge clk) begin
    if (master_rst_n && valid) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got par_out=0x%0h word_cnt=%0d expected no valid", par_out, word_cnt);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_par_out", 32'(par_out), 32'(e.d));
        chk("sb_word_cnt", 32'(word_cnt), 32'(e.c));
        chk("sb_bit_idx_wrap", 32'(bit_idx), 32'd0);
        if (e.gap != 0) chk("sb_valid_gap", 32'(cyc - last_v), 32'(e.gap));
      end
      last_v = cyc;
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start  = 1'b1;
      ser_in = i[0];
      chk_all_zero("reset_hold");
    end
    @(negedge clk);
    start = 1'b0;
    master_rst_n = 1'b1;
    send_word(8'hAA, 0);
    send_word(8'h3C, 8);
    idle(2);
    chk("after_stream_busy", 32'(busy), 32'd0);
    send_bits(8'hFF, 5);
    @(negedge clk);
    chk("abort_before_busy", 32'(busy), 32'd1);
    chk("abort_before_idx", 32'(bit_idx), 32'd5);
    start = 1'b0;
    idle(1);
    chk("abort_par_out", 32'(par_out), 32'h3C);
    chk("abort_bit_idx", 32'(bit_idx), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_word_cnt", 32'(word_cnt), 32'd2);
    send_word(8'h01, 0);
    idle(2);
    send_bits(8'h80, 7);
    @(negedge clk);
    start  = 1'b0;
    ser_in = 1'b1;
    idle(2);
    chk("late_fall_par_out", 32'(par_out), 32'h01);
    chk("late_fall_word_cnt", 32'(word_cnt), 32'd3);
    send_bits(8'h07, 3);
    @(posedge clk);
    #2;
    chk("midword_idx_pre", 32'(bit_idx), 32'd3);
    master_rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    wc = 8'd0;
    @(negedge clk);
    start = 1'b0;
    idle(2);
    master_rst_n = 1'b1;
    for (int i = 0; i < 256; i++) send_word(8'((i * 37 + 5) & 8'hFF), i == 0 ? 0 : 8);
    idle(2);
    chk("wrap_word_cnt", 32'(word_cnt), 32'd0);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) chk("pending_words", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got time %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/sequential_collect.md
Name: sequential_collect

Overview:
Serial-to-parallel receiver for the bit stream produced by the sequential mux-select serializer. While `start` is high, it samples one bit per clock into the slot chosen by an internal mod-WIDTH index counter. When a word is complete, it presents the word on `par_out` with a one-cycle `valid` strobe. It sits at the far end of the serial link and recovers the 8-bit word the serializer walked through.

Parameters:
- WIDTH, 8, word length in bits and counter modulus; must be a power of 2, >= 2.
- CNT_W, $clog2(WIDTH), width of bit index.
- WCNT_W, 8, width of completed-word counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- master_rst_n  input  1  asynchronous, active-low reset.
- start  input  1  frame enable, same signal that drives the serializer; high = stream active.
- ser_in  input  1  serial data bit, LSB of word first.
- par_out  output  WIDTH  last completed word; holds until the next word completes.
- valid  output  1  one-cycle pulse, the cycle `par_out` updates.
- busy  output  1  high while in COLLECT state.
- bit_idx  output  CNT_W  slot that the next sampled bit will occupy.
- word_cnt  output  WCNT_W  number of completed words since reset; wraps modulo 2^WCNT_W.

Behaviour:
- Reset (master_rst_n=0, async assert):
  - par_out=0, valid=0, busy=0, bit_idx=0, word_cnt=0.
  - Shift buffer cleared; state=IDLE.
- Deassertion is sampled synchronously; first active edge is the first edge with master_rst_n=1.
- States: IDLE, COLLECT.
  - IDLE: start=0 at edge -> stay IDLE, bit_idx held at 0. start=1 at edge -> sample ser_in into buf[0], bit_idx<=1, go COLLECT.
  - COLLECT, start=1 at edge: buf[bit_idx]<=ser_in, bit_idx<=bit_idx+1 mod WIDTH.
  - COLLECT, start=1 and bit_idx==WIDTH-1: par_out<={ser_in, buf[WIDTH-2:0]}, valid<=1, word_cnt<=word_cnt+1, bit_idx<=0, remain COLLECT.
  - Back-to-back words therefore have no gap.
  - COLLECT, start=0 at edge: abort. Partial word discarded, buf cleared, bit_idx<=0, go IDLE. par_out keeps the last complete word; valid=0; word_cnt unchanged.
- Timing:
  - Latency: the first bit enters at edge k; valid is high for the cycle after edge k+WIDTH-1.
  - valid is registered and high for exactly one cycle per word.
- Outputs:
  - busy = (state==COLLECT), registered.
  - par_out changes only at a word-completion edge or on reset.
- Boundaries:
  - start falling on the same edge as the last bit: start=0 wins. The word is aborted, no valid, no word_cnt increment.
  - word_cnt at all-ones plus one completion -> 0.
  - Reset asserted mid-word: immediate clear of all state and outputs, including par_out.
  - ser_in is don't-care in IDLE.

Decomposition:
- Shared package `sequential_select_pkg`:
  - WIDTH default constant.
  - State enum {IDLE, COLLECT}.
  - Bit-order convention constant (LSB_FIRST=1), shared with the serializer so both ends agree.
- Sub-module `bit_index_counter`:
  - Mod-WIDTH counter with synchronous clear, enable, and wrap flag.
  - The same counter form the serializer uses for its select lines.

Test Plan:
- Reset: hold master_rst_n=0 across edges with start=1, ser_in toggling -> par_out=0, valid=0, busy=0, bit_idx=0, word_cnt=0 throughout.
- Single word: release reset, start=1, ser_in LSB-first of 8'hAA (0,1,0,1,0,1,0,1) -> after the 8th edge par_out=8'hAA, valid high 1 cycle, word_cnt=1.
- Continuous stream: 8'hAA then 8'h3C back-to-back with start held high -> valid pulses 8 cycles apart; par_out=8'hAA then 8'h3C; word_cnt=2; no idle cycle between words.
- Abort: start=1 for 5 bits of 8'hFF, then start=0 -> no valid, par_out keeps the prior word, bit_idx=0, busy=0. Restart with 8'h01 -> par_out=8'h01.
- Async reset mid-word: assert master_rst_n=0 between edges after 3 bits -> all outputs 0 immediately, without waiting for clk.
- Wrap: 256 consecutive words -> word_cnt returns to 0 on the 256th valid; bit_idx wraps 7->0 on every word.
